// File: rtl/char_pkg.sv
// Character controller types, reset position and default physics constants.
package char_pkg;

  import vga_pkg::*;

  typedef enum logic [1:0] {
    GROUND  = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2
  } char_state_t;

  localparam int WALK_SPEED_DEF    = 3;
  localparam int JUMP_V_DEF        = 12;
  localparam int GRAVITY_DEF       = 1;
  localparam int MAX_FALL_DEF      = 12;
  localparam int GROUND_OFFSET_DEF = 50;
  localparam int CHAR_HGT_DEF      = 26;

  localparam logic [11:0] RST_POS_X = 12'(HOR_PIXELS / 5);
  localparam logic [11:0] RST_POS_Y = 12'(VER_PIXELS - GROUND_OFFSET_DEF - CHAR_HGT_DEF);

endpackage

// File: rtl/vga_pkg.sv
// Screen geometry shared by the VGA timing, drawing and game-logic blocks.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

endpackage

// File: rtl/frame_tick_gen.sv
// One-clock frame strobe on the rising edge of vblnk.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_d;

  // Reset high so a vblnk already asserted out of reset is not taken as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vblnk_d <= 1'b1;
    else     vblnk_d <= vblnk;
  end

  assign tick = vblnk & ~vblnk_d;

endmodule

// File: rtl/char_ctl.sv
// Per-frame character motion: walking with screen clamp, jump/gravity FSM.
module char_ctl
  import vga_pkg::*;
  import char_pkg::*;
#(
  parameter int WALK_SPEED    = WALK_SPEED_DEF,
  parameter int JUMP_V        = JUMP_V_DEF,
  parameter int GRAVITY       = GRAVITY_DEF,
  parameter int MAX_FALL      = MAX_FALL_DEF,
  parameter int GROUND_OFFSET = GROUND_OFFSET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic [11:0] char_hgt,
  input  logic [11:0] char_lng,
  output logic [11:0] pos_x,
  output logic [11:0] pos_y,
  output logic        flip_h,
  output logic        on_ground
);

  localparam logic signed [12:0] STEP_X   = 13'(WALK_SPEED);
  localparam logic signed [12:0] SCREEN_W = 13'(HOR_PIXELS);
  localparam logic signed [13:0] GROUND_Y = 14'(VER_PIXELS - GROUND_OFFSET);
  localparam logic signed [7:0]  VEL_JUMP = 8'(-JUMP_V);
  localparam logic signed [7:0]  VEL_G    = 8'(GRAVITY);
  localparam logic signed [7:0]  VEL_MAX  = 8'(MAX_FALL);

  function automatic logic signed [12:0] clamp_x(input logic signed [12:0] v,
                                                  input logic signed [12:0] lo,
                                                  input logic signed [12:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic signed [7:0] cap_fall(input logic signed [7:0] v);
    return (v > VEL_MAX) ? VEL_MAX : v;
  endfunction

  logic tick;

  frame_tick_gen u_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (tick)
  );

  char_state_t       state, state_nxt;
  logic signed [7:0] vel, vel_nxt, vel_inc;
  logic              jump_armed, armed_nxt;
  logic [11:0]       x_nxt, y_nxt;
  logic              flip_nxt;

  logic signed [12:0] x_s, x_step, x_lo, x_hi;
  logic signed [13:0] y_s, vel_ext, y_sum, hgt_s, rest_y;

  assign x_s     = {1'b0, pos_x};
  assign x_lo    = {1'b0, char_lng};
  assign x_hi    = SCREEN_W - x_lo;
  assign y_s     = {2'b00, pos_y};
  assign hgt_s   = {2'b00, char_hgt};
  assign vel_ext = 14'(vel);
  assign y_sum   = y_s + vel_ext;
  assign rest_y  = GROUND_Y - hgt_s;
  assign vel_inc = vel + VEL_G;

  always_comb begin
    state_nxt = state;
    vel_nxt   = vel;
    armed_nxt = jump_armed;
    y_nxt     = pos_y;
    flip_nxt  = flip_h;
    x_step    = x_s;

    if (btn_left && !btn_right) begin
      x_step   = x_s - STEP_X;
      flip_nxt = 1'b1;
    end else if (btn_right && !btn_left) begin
      x_step   = x_s + STEP_X;
      flip_nxt = 1'b0;
    end
    x_nxt = 12'(clamp_x(x_step, x_lo, x_hi));

    case (state)
      GROUND: begin
        // Take-off tick keeps pos_y; motion starts on the following tick.
        if (btn_jump && jump_armed) begin
          vel_nxt   = VEL_JUMP;
          state_nxt = RISING;
          armed_nxt = 1'b0;
        end else begin
          y_nxt = 12'(rest_y);
        end
      end
      RISING: begin
        if (y_sum < hgt_s) begin
          y_nxt     = char_hgt;
          vel_nxt   = '0;
          state_nxt = FALLING;
        end else begin
          y_nxt   = 12'(y_sum);
          vel_nxt = vel_inc;
          if (!vel_inc[7]) state_nxt = FALLING;
        end
      end
      FALLING: begin
        if (y_sum >= rest_y) begin
          y_nxt     = 12'(rest_y);
          vel_nxt   = '0;
          state_nxt = GROUND;
        end else begin
          y_nxt   = 12'(y_sum);
          vel_nxt = cap_fall(vel_inc);
        end
      end
      default: begin
        vel_nxt   = '0;
        state_nxt = GROUND;
      end
    endcase

    if (!btn_jump) armed_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= GROUND;
      vel        <= '0;
      jump_armed <= 1'b1;
      pos_x      <= RST_POS_X;
      pos_y      <= RST_POS_Y;
      flip_h     <= 1'b0;
      on_ground  <= 1'b1;
    end else if (tick) begin
      state      <= state_nxt;
      vel        <= vel_nxt;
      jump_armed <= armed_nxt;
      pos_x      <= x_nxt;
      pos_y      <= y_nxt;
      flip_h     <= flip_nxt;
      on_ground  <= (state_nxt == GROUND);
    end
  end

endmodule

// File: tb/tb_char_ctl.sv
// Bench for char_ctl: vector table, hand-written jump/clamp/reset sequences, random frames vs model.
module tb_char_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk = 1'b0;
  logic        btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [11:0] char_hgt = 12'd26;
  logic [11:0] char_lng = 12'd19;
  logic [11:0] pos_x, pos_y;
  logic        flip_h, on_ground;

  char_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .vblnk     (vblnk),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .char_hgt  (char_hgt),
    .char_lng  (char_lng),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .flip_h    (flip_h),
    .on_ground (on_ground)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = standing, 1 = going up, 2 = coming down.
  int m_x, m_y, m_vel, m_phase;
  bit m_flip, m_armed;

  task automatic model_reset();
    m_x = 160; m_y = 524; m_vel = 0; m_phase = 0; m_flip = 0; m_armed = 1;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j);
    int rest, hgt, lng;
    hgt  = int'(char_hgt);
    lng  = int'(char_lng);
    rest = 600 - 50 - hgt;
    if (l && !r) begin m_x = m_x - 3; m_flip = 1; end
    else if (r && !l) begin m_x = m_x + 3; m_flip = 0; end
    if (m_x < lng) m_x = lng;
    if (m_x > 800 - lng) m_x = 800 - lng;
    if (m_phase == 0) begin
      if (j && m_armed) begin m_vel = -12; m_phase = 1; m_armed = 0; end
      else m_y = rest;
    end else if (m_phase == 1) begin
      if (m_y + m_vel < hgt) begin m_y = hgt; m_vel = 0; m_phase = 2; end
      else begin
        m_y = m_y + m_vel;
        m_vel = m_vel + 1;
        if (m_vel >= 0) m_phase = 2;
      end
    end else begin
      if (m_y + m_vel >= rest) begin m_y = rest; m_vel = 0; m_phase = 0; end
      else begin
        m_y = m_y + m_vel;
        m_vel = (m_vel + 1 > 12) ? 12 : m_vel + 1;
      end
    end
    if (!j) m_armed = 1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pos_x"}, int'(pos_x), m_x);
    chk({tag, ".pos_y"}, int'(pos_y), m_y);
    chk({tag, ".flip_h"}, int'(flip_h), int'(m_flip));
    chk({tag, ".on_ground"}, int'(on_ground), (m_phase == 0) ? 1 : 0);
  endtask

  // One frame: buttons held across the vblnk rising edge, outputs sampled afterwards.
  task automatic do_frame(input bit l, input bit r, input bit j);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j;
    vblnk = 1'b1;
    @(negedge clk);
    vblnk = 1'b0;
    @(negedge clk);
    model_tick(l, r, j);
    chk_model("model");
  endtask

  typedef struct {
    bit l, r, j;
    int x, y;
    bit flip, gnd;
  } vec_t;

  vec_t vecs[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, takeoffs;
    bit prev_gnd;

    for (int i = 0; i < 18; i++) begin
      vecs[i].j = 0; vecs[i].y = 524; vecs[i].gnd = 1;
      if (i < 3) begin
        vecs[i].l = 0; vecs[i].r = 0; vecs[i].x = 160; vecs[i].flip = 0;
      end else if (i < 13) begin
        vecs[i].l = 1; vecs[i].r = 0; vecs[i].x = 160 - 3 * (i - 2); vecs[i].flip = 1;
      end else begin
        vecs[i].l = 1; vecs[i].r = 1; vecs[i].x = 130; vecs[i].flip = 1;
      end
    end

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.pos_x", int'(pos_x), 160);
    chk("rst.pos_y", int'(pos_y), 524);
    chk("rst.flip_h", int'(flip_h), 0);
    chk("rst.on_ground", int'(on_ground), 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      do_frame(vecs[i].l, vecs[i].r, vecs[i].j);
      chk($sformatf("vec%0d.pos_x", i), int'(pos_x), vecs[i].x);
      chk($sformatf("vec%0d.pos_y", i), int'(pos_y), vecs[i].y);
      chk($sformatf("vec%0d.flip_h", i), int'(flip_h), int'(vecs[i].flip));
      chk($sformatf("vec%0d.on_ground", i), int'(on_ground), int'(vecs[i].gnd));
    end

    // Left clamp, then walk right to 775 and clamp at the right edge.
    repeat (60) do_frame(1, 0, 0);
    chk("clamp_left.pos_x", int'(pos_x), 19);
    chk("clamp_left.flip_h", int'(flip_h), 1);
    repeat (252) do_frame(0, 1, 0);
    chk("walk_right.pos_x", int'(pos_x), 775);
    do_frame(0, 1, 0);
    chk("right1.pos_x", int'(pos_x), 778);
    do_frame(0, 1, 0);
    do_frame(0, 1, 0);
    chk("clamp_right.pos_x", int'(pos_x), 781);
    do_frame(0, 1, 0);
    chk("clamp_right_hold.pos_x", int'(pos_x), 781);

    // Single-tick jump pulse.
    do_frame(0, 0, 1);
    chk("jump0.on_ground", int'(on_ground), 0);
    chk("jump0.pos_y", int'(pos_y), 524);
    repeat (12) do_frame(0, 0, 0);
    chk("apex.pos_y", int'(pos_y), 446);
    chk("apex.on_ground", int'(on_ground), 0);
    cnt = 0;
    while (!on_ground && cnt < 40) begin
      do_frame(0, 0, 0);
      cnt++;
    end
    chk("fall_ticks", cnt, 13);
    chk("land.pos_y", int'(pos_y), 524);

    // Press and release between ticks is never seen.
    @(negedge clk); btn_jump = 1'b1;
    @(negedge clk); btn_jump = 1'b0;
    do_frame(0, 0, 0);
    chk("glitch.on_ground", int'(on_ground), 1);

    // Jump held continuously: one take-off only.
    takeoffs = 0;
    prev_gnd = on_ground;
    repeat (45) begin
      do_frame(0, 0, 1);
      if (prev_gnd && !on_ground) takeoffs++;
      prev_gnd = on_ground;
    end
    chk("held.takeoffs", takeoffs, 1);
    chk("held.on_ground", int'(on_ground), 1);
    do_frame(0, 0, 0);
    do_frame(0, 0, 1);
    chk("rearm.on_ground", int'(on_ground), 0);
    cnt = 0;
    while (!on_ground && cnt < 40) begin
      do_frame(0, 0, 0);
      cnt++;
    end
    chk("rearm.landed", int'(on_ground), 1);

    // Asynchronous reset mid-jump.
    do_frame(0, 0, 1);
    repeat (6) do_frame(0, 0, 0);
    chk("midjump.pos_y", int'(pos_y), 467);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst.pos_x", int'(pos_x), 160);
    chk("async_rst.pos_y", int'(pos_y), 524);
    chk("async_rst.flip_h", int'(flip_h), 0);
    chk("async_rst.on_ground", int'(on_ground), 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    btn_jump = 1'b0;

    // Random frames, including a tall sprite that reaches the ceiling.
    for (int f = 0; f < 400; f++) begin
      if (f % 50 == 0 && m_phase == 0)
        char_hgt = ($urandom_range(0, 1) == 1) ? 12'd270 : 12'd26;
      do_frame($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
